// File: rtl/mure_pkg.sv
// Shared trace-encoder types: block record, field widths, popcount helper.
// Used by te_block_serializer and its lane packer.
package mure_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IRETIRE_LEN = 4;
  localparam int unsigned ITYPE_LEN   = 4;
  localparam int unsigned CAUSE_LEN   = 5;
  localparam int unsigned PRIV_LEN    = 2;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        iaddr;
  } te_block_t;

  function automatic logic [5:0] te_popcount(
    input logic [31:0] v
  );
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/te_block_serializer_if.sv
// Group-in / block-out bundle of the trace block serializer.
// slave = serializer side, master = retirement/encoder side.
interface te_block_serializer_if #(
  parameter int unsigned N = 2
) ();
  import mure_pkg::*;

  logic [N-1:0]                  valid_i;
  logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
  logic [N-1:0]                  ilastsize_i;
  logic [N-1:0][ITYPE_LEN-1:0]   itype_i;
  logic [N-1:0][CAUSE_LEN-1:0]   cause_i;
  logic [N-1:0][XLEN-1:0]        tval_i;
  logic [N-1:0][PRIV_LEN-1:0]    priv_i;
  logic [N-1:0][XLEN-1:0]        iaddr_i;
  logic                          ready_o;
  logic                          overflow_o;
  logic                          clear_overflow_i;

  logic                   valid_o;
  logic                   ready_i;
  logic [IRETIRE_LEN-1:0] iretire_o;
  logic                   ilastsize_o;
  logic [ITYPE_LEN-1:0]   itype_o;
  logic [CAUSE_LEN-1:0]   cause_o;
  logic [XLEN-1:0]        tval_o;
  logic [PRIV_LEN-1:0]    priv_o;
  logic [XLEN-1:0]        iaddr_o;

  modport slave (
    input  valid_i, iretire_i, ilastsize_i,
    input  itype_i, cause_i, tval_i,
    input  priv_i, iaddr_i,
    input  clear_overflow_i, ready_i,
    output ready_o, overflow_o, valid_o,
    output iretire_o, ilastsize_o, itype_o,
    output cause_o, tval_o, priv_o, iaddr_o
  );

  modport master (
    output valid_i, iretire_i, ilastsize_i,
    output itype_i, cause_i, tval_i,
    output priv_i, iaddr_i,
    output clear_overflow_i, ready_i,
    input  ready_o, overflow_o, valid_o,
    input  iretire_o, ilastsize_o, itype_o,
    input  cause_o, tval_o, priv_o, iaddr_o
  );

endinterface

// File: rtl/te_block_serializer_lane_packer.sv
// Per-lane write offsets (prefix count of valid lanes) and group size.
// Invalid lanes are zeroed so they never carry stray data.
module te_lane_packer
  import mure_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]          valid_i,
  input  te_block_t [N-1:0]     blk_i,
  output logic [N-1:0][CW-1:0]  off_o,
  output logic [CW-1:0]         total_o,
  output te_block_t [N-1:0]     blk_o
);

  logic [CW-1:0] acc;

  always_comb begin
    acc   = '0;
    off_o = '0;
    blk_o = '0;
    for (int i = 0; i < N; i++) begin
      off_o[i] = acc;
      blk_o[i] = valid_i[i] ? blk_i[i] : '0;
      acc      = acc + CW'(valid_i[i]);
    end
  end

  assign total_o = CW'(te_popcount(32'(valid_i)));

endmodule

// File: rtl/te_block_serializer.sv
// Packs up to N retirement blocks per cycle into a ring, drains one per cycle.
// Define TE_SERIALIZER_STATS_EN for blocks_in/blocks_out/dropped counters.
module te_block_serializer
  import mure_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 8
) (
  input logic clk_i,
  input logic rst_ni,
  te_block_serializer_if.slave bus
`ifdef TE_SERIALIZER_STATS_EN
  ,
  output logic [31:0] blocks_in_o,
  output logic [31:0] blocks_out_o,
  output logic [31:0] dropped_o
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(N + 1);

  te_block_t [N-1:0]         lane_blk;
  te_block_t [N-1:0]         pk_blk;
  logic [N-1:0][CW-1:0]      off;
  logic [CW-1:0]             total;
  logic [N-1:0][AW-1:0]      waddr;

  te_block_t                 mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [CNTW-1:0]           count;
  logic                      ovf;
  logic                      any_v;
  logic                      push;
  logic                      pop;
  logic                      drop;
  logic [CW-1:0]             pushed;
  te_block_t                 head;

  always_comb begin
    lane_blk = '0;
    for (int i = 0; i < N; i++) begin
      lane_blk[i] = '{
        iretire:   bus.iretire_i[i],
        ilastsize: bus.ilastsize_i[i],
        itype:     bus.itype_i[i],
        cause:     bus.cause_i[i],
        tval:      bus.tval_i[i],
        priv:      bus.priv_i[i],
        iaddr:     bus.iaddr_i[i]
      };
    end
  end

  te_lane_packer #(.N(N), .CW(CW)) u_packer (
    .valid_i (bus.valid_i),
    .blk_i   (lane_blk),
    .off_o   (off),
    .total_o (total),
    .blk_o   (pk_blk)
  );

  always_comb begin
    waddr = '0;
    for (int i = 0; i < N; i++) begin
      waddr[i] = wr_ptr + AW'(off[i]);
    end
  end

  // Room is judged on the registered count only; a pop this
  // cycle never admits the current group.
  assign bus.ready_o = (count <= CNTW'(DEPTH - N));
  assign any_v       = |bus.valid_i;
  assign push        = bus.ready_o && any_v;
  assign drop        = !bus.ready_o && any_v;
  assign bus.valid_o = (count != '0);
  assign pop         = bus.valid_o && bus.ready_i;
  assign pushed      = push ? total : '0;

  assign head            = mem[rd_ptr];
  assign bus.iretire_o   = head.iretire;
  assign bus.ilastsize_o = head.ilastsize;
  assign bus.itype_o     = head.itype;
  assign bus.cause_o     = head.cause;
  assign bus.tval_o      = head.tval;
  assign bus.priv_o      = head.priv;
  assign bus.iaddr_o     = head.iaddr;
  assign bus.overflow_o  = ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < DEPTH; d++) begin
        mem[d] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        for (int i = 0; i < N; i++) begin
          if (bus.valid_i[i]) begin
            mem[waddr[i]] <= pk_blk[i];
          end
        end
        wr_ptr <= wr_ptr + AW'(total);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CNTW'(pushed) - CNTW'(pop);
      if (bus.clear_overflow_i) begin
        ovf <= 1'b0;
      end else if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef TE_SERIALIZER_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blocks_in_o  <= '0;
      blocks_out_o <= '0;
      dropped_o    <= '0;
    end else if (bus.clear_overflow_i) begin
      blocks_in_o  <= '0;
      blocks_out_o <= '0;
      dropped_o    <= '0;
    end else begin
      blocks_in_o  <= blocks_in_o + 32'(pushed);
      blocks_out_o <= blocks_out_o + 32'(pop);
      if (drop) begin
        dropped_o <= dropped_o + 32'(total);
      end
    end
  end
`endif

endmodule

// File: tb/tb_te_block_serializer.sv
// Bench for te_block_serializer: directed steps then random traffic,
// checked against a queue model of the buffer.
module tb_te_block_serializer;
  import mure_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  te_block_serializer_if #(.N(N)) bif ();

`ifdef TE_SERIALIZER_STATS_EN
  logic [31:0] blocks_in_o;
  logic [31:0] blocks_out_o;
  logic [31:0] dropped_o;
`endif

  te_block_serializer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bif)
`ifdef TE_SERIALIZER_STATS_EN
    ,
    .blocks_in_o  (blocks_in_o),
    .blocks_out_o (blocks_out_o),
    .dropped_o    (dropped_o)
`endif
  );

  int errors = 0;
  int checks = 0;

  te_block_t   q[$];
  logic        m_ovf;
  int unsigned m_in;
  int unsigned m_out;
  int unsigned m_drop;
  te_block_t   lane [N];

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic te_block_t rand_blk();
    te_block_t b;
    b.iretire   = IRETIRE_LEN'($urandom);
    b.ilastsize = 1'($urandom);
    b.itype     = ITYPE_LEN'($urandom);
    b.cause     = CAUSE_LEN'($urandom);
    b.tval      = $urandom;
    b.priv      = PRIV_LEN'($urandom);
    b.iaddr     = $urandom;
    return b;
  endfunction

  function automatic te_block_t out_blk();
    te_block_t b;
    b.iretire   = bif.iretire_o;
    b.ilastsize = bif.ilastsize_o;
    b.itype     = bif.itype_o;
    b.cause     = bif.cause_o;
    b.tval      = bif.tval_o;
    b.priv      = bif.priv_o;
    b.iaddr     = bif.iaddr_o;
    return b;
  endfunction

  task automatic check_state();
    chk("valid_o", bif.valid_o, q.size() != 0);
    chk("ready_o", bif.ready_o, q.size() <= DEPTH - N);
    chk("overflow_o", bif.overflow_o, m_ovf);
    chk("count", dut.count, q.size());
    if (q.size() != 0) chk("head", out_blk(), q[0]);
`ifdef TE_SERIALIZER_STATS_EN
    chk("blocks_in", blocks_in_o, m_in);
    chk("blocks_out", blocks_out_o, m_out);
    chk("dropped", dropped_o, m_drop);
`endif
  endtask

  // One cycle: drive at negedge, check, advance model, wait posedge.
  task automatic step(input logic [N-1:0] v,
                      input logic rdy,
                      input logic clr);
    bit room;
    bit popd;
    int pc;
    @(negedge clk_i);
    bif.valid_i = v;
    for (int i = 0; i < N; i++) begin
      bif.iretire_i[i]   = lane[i].iretire;
      bif.ilastsize_i[i] = lane[i].ilastsize;
      bif.itype_i[i]     = lane[i].itype;
      bif.cause_i[i]     = lane[i].cause;
      bif.tval_i[i]      = lane[i].tval;
      bif.priv_i[i]      = lane[i].priv;
      bif.iaddr_i[i]     = lane[i].iaddr;
    end
    bif.ready_i          = rdy;
    bif.clear_overflow_i = clr;
    #1;
    check_state();
    room = (q.size() <= DEPTH - N);
    popd = (q.size() != 0) && rdy;
    pc   = $countones(v);
    if (popd) void'(q.pop_front());
    if (pc != 0 && room) begin
      for (int i = 0; i < N; i++)
        if (v[i]) q.push_back(lane[i]);
    end
    if (clr) begin
      m_ovf = 1'b0; m_in = 0; m_out = 0; m_drop = 0;
    end else begin
      if (pc != 0 && !room) begin
        m_ovf  = 1'b1;
        m_drop = m_drop + pc;
      end
      if (pc != 0 && room) m_in = m_in + pc;
      if (popd) m_out = m_out + 1;
    end
    @(posedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_valid_o", bif.valid_o, 1'b0);
    chk("rst_ready_o", bif.ready_o, 1'b1);
    chk("rst_overflow_o", bif.overflow_o, 1'b0);
    chk("rst_iaddr_o", bif.iaddr_o, 32'h0);
    q.delete();
    m_ovf = 1'b0; m_in = 0; m_out = 0; m_drop = 0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < N; i++) lane[i] = rand_blk();
  endtask

  initial begin
    m_ovf = 1'b0; m_in = 0; m_out = 0; m_drop = 0;
    bif.valid_i          = '0;
    bif.iretire_i        = '0;
    bif.ilastsize_i      = '0;
    bif.itype_i          = '0;
    bif.cause_i          = '0;
    bif.tval_i           = '0;
    bif.priv_i           = '0;
    bif.iaddr_i          = '0;
    bif.ready_i          = 1'b0;
    bif.clear_overflow_i = 1'b0;
    for (int i = 0; i < N; i++) lane[i] = '0;

    #12;
    chk("init_valid_o", bif.valid_o, 1'b0);
    chk("init_ready_o", bif.ready_o, 1'b1);
    chk("init_overflow_o", bif.overflow_o, 1'b0);
    chk("init_data", out_blk(), 80'h0);
    rst_ni = 1'b1;

    // Two-lane push from empty, drained back to back.
    rand_lanes();
    lane[0].iaddr = 32'h100;
    lane[1].iaddr = 32'h104;
    step(2'b11, 1'b1, 1'b0);
    #1 chk("t1_v1", bif.valid_o, 1'b1);
    chk("t1_a0", bif.iaddr_o, 32'h100);
    step(2'b00, 1'b1, 1'b0);
    #1 chk("t1_a1", bif.iaddr_o, 32'h104);
    step(2'b00, 1'b1, 1'b0);
    #1 chk("t1_empty", bif.valid_o, 1'b0);

    // Single upper lane is packed to the next slot.
    rand_lanes();
    lane[1].iaddr = 32'h200;
    step(2'b10, 1'b0, 1'b0);
    #1 chk("t2_a", bif.iaddr_o, 32'h200);
    chk("t2_cnt", dut.count, 4'd1);
    step(2'b00, 1'b1, 1'b0);

    // Fill, overflow, then clear racing a new drop.
    do_reset();
    repeat (4) begin
      rand_lanes();
      step(2'b11, 1'b0, 1'b0);
    end
    #1 chk("t3_full", bif.ready_o, 1'b0);
    rand_lanes();
    step(2'b11, 1'b0, 1'b0);
    #1 chk("t3_ovf", bif.overflow_o, 1'b1);
    step(2'b00, 1'b0, 1'b0);
    rand_lanes();
    step(2'b11, 1'b0, 1'b1);
    #1 chk("t3_clr", bif.overflow_o, 1'b0);
    repeat (9) step(2'b00, 1'b1, 1'b0);

    // Wrap: count 7 at wr 7, pop one, push two across 7 -> 0.
    do_reset();
    repeat (3) begin
      rand_lanes();
      step(2'b11, 1'b0, 1'b0);
    end
    rand_lanes();
    step(2'b01, 1'b0, 1'b0);
    #1 chk("t4_wr7", dut.wr_ptr, 3'd7);
    step(2'b00, 1'b1, 1'b0);
    rand_lanes();
    step(2'b11, 1'b0, 1'b0);
    #1 chk("t4_wr1", dut.wr_ptr, 3'd1);
    repeat (2) step(2'b00, 1'b1, 1'b0);
    // Same-cycle push and pop at count 6.
    rand_lanes();
    step(2'b11, 1'b1, 1'b0);
    #1 chk("t5_cnt", dut.count, 4'd7);
    chk("t5_rdy", bif.ready_o, 1'b0);
    repeat (8) step(2'b00, 1'b1, 1'b0);

    // Asynchronous reset with blocks buffered.
    repeat (2) begin
      rand_lanes();
      step(2'b11, 1'b0, 1'b0);
    end
    rand_lanes();
    step(2'b01, 1'b0, 1'b0);
    #1 chk("t6_cnt", dut.count, 4'd5);
    do_reset();
    repeat (3) step(2'b00, 1'b1, 1'b0);

    // Random traffic with varying drain pressure.
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 100; k++) begin
        rand_lanes();
        step(N'($urandom_range(0, 3)),
             ($urandom_range(0, 3) < ph + 1),
             ($urandom_range(0, 39) == 0));
      end
    end
    repeat (10) step(2'b00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
